rf_port_arbiter: RTL and testbench
==================================

Name: rf_port_arbiter

Overview:
- Shares the single command port of the 32x32 register file between two clients, e.g. a decode/operand-fetch unit and a writeback unit.
- Each client issues either a read (two addresses) or a write (one address plus data).
- The arbiter grants one command per cycle using round-robin.
- It drives the register file's READ/WRITE/ADDR/DATA_W inputs from registers and returns read data to the granted client with a valid pulse.

Parameters:
- DATA_WIDTH, 32, width of register data (matches `DATA_WIDTH).
- ADDR_WIDTH, 5, register address width (matches `REG_ADDR_INDEX_LIMIT+1).

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  2  per-client request; bit k belongs to client k.
- WR  in  2  per-client op type: 1 = write, 0 = read.
- ADDR_A0 / ADDR_A1  in  ADDR_WIDTH each  write address, or read port-1 address.
- ADDR_B0 / ADDR_B1  in  ADDR_WIDTH each  read port-2 address (ignored on write).
- WDATA0 / WDATA1  in  DATA_WIDTH each  write data.
- GNT  out  2  one-hot grant pulse, one cycle.
- RVALID  out  2  one-hot read-data-valid pulse, one cycle.
- RDATA1 / RDATA2  out  DATA_WIDTH each  read data, shared by both clients and qualified by RVALID.
- RF_READ / RF_WRITE  out  1 each  to the register file READ / WRITE.
- RF_ADDR_R1 / RF_ADDR_R2 / RF_ADDR_W  out  ADDR_WIDTH each  to the register file address inputs.
- RF_DATA_W  out  DATA_WIDTH  to the register file DATA_W.
- RF_DATA_R1 / RF_DATA_R2  in  DATA_WIDTH each  from the register file.

Behaviour:
- Reset (RST=0, async):
  - All outputs go to 0.
  - The last-grant pointer is set to 1, so client 0 wins the first tie.
  - Any in-flight op is dropped and no RVALID is generated for it.
- Handshake:
  - A client raises REQ with WR/ADDR/WDATA stable and holds them until it samples GNT[k]=1.
  - It may change or drop them at the edge following that cycle.
- Eligibility: client k is eligible at edge N if REQ[k]=1 and GNT[k] is not 1 in cycle N. This prevents re-grant of the request currently being acknowledged.
- Arbitration at edge N:
  - Exactly one eligible client: it wins.
  - Both eligible: the client that is not the last-grant pointer wins.
  - The pointer updates to the winner.
- Issue: in cycle N+1 following edge N:
  - GNT[w]=1.
  - RF_* command registers carry the winner's op: RF_READ=~WR, RF_WRITE=WR.
  - On a read: RF_ADDR_R1=ADDR_A, RF_ADDR_R2=ADDR_B.
  - On a write: RF_ADDR_W=ADDR_A, RF_DATA_W=WDATA.
- No eligible client: RF_READ=RF_WRITE=0 and GNT=0. Address/data registers hold their last values.
- Read return:
  - The register file captures on the edge ending the issue cycle.
  - In the next cycle, RVALID[w]=1 and RDATA1/2 = RF_DATA_R1/2, passed through combinationally.
  - Read latency from GNT to RVALID is 1 cycle.
- Write: complete at the edge ending the issue cycle. No response pulse.
- Throughput: one op per cycle when the clients alternate. A single client alone gets one op per 2 cycles.
- FSM: IDLE -> ISSUE when any client is eligible. ISSUE -> ISSUE when any client is eligible, else ISSUE -> IDLE.
- A separate 1-bit RESP flag tracks the read return and overlaps the next ISSUE.
- Read and write are never issued in the same cycle. RF_READ & RF_WRITE = 0 always.
- A read issued the cycle after a write to the same address returns the new data.

Optional Feature:
- Macro: RF_ARB_FIXED_PRIORITY_EN.
- Defined: client 0 always wins when both clients are eligible, and the pointer is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package/include holds:
  - op-type constants OP_READ=0, OP_WRITE=1;
  - FSM state encodings IDLE=0, ISSUE=1;
  - DATA/ADDR widths taken from existing project definitions.
- One sub-module, rf_rr_pick2: combinational 2-way round-robin picker (inputs: eligible, pointer; output: winner one-hot). The macro is handled inside it.

Test Plan:
- Reset: RST low for 10ns, then high -> all RF_*, GNT, RVALID = 0. With both requesting, client 0 is granted first.
- Client 0 writes 0xDEADBEEF to reg 5, then client 0 reads A=5, B=5:
  - GNT[0] in issue cycle, RF_WRITE=1, RF_ADDR_W=5.
  - Read: RVALID[0] one cycle after GNT, RDATA1 = RDATA2 = 0xDEADBEEF.
- Both clients hold REQ for 6 cycles (client 0 writes regs 1..3 with 0x11, client 1 writes regs 8..10 with 0x22):
  - Grants alternate 0,1,0,1,0,1 with no idle cycle.
  - A later readback confirms the data.
- Client 1 alone holding REQ for 3 ops -> GNT[1] in every other cycle, RF idle in between.
- Reset asserted during the cycle a read is issued -> no RVALID afterwards, all outputs 0 immediately (asynchronous).
- With RF_ARB_FIXED_PRIORITY_EN defined and both requesting continuously -> client 0 wins every eligible cycle; client 1 wins only in cycles where GNT[0]=1.

Source files
------------

// File: rtl/rf_port_arbiter_pkg.sv
// ============================================================================
// Module      : rf_port_arbiter_pkg
// Description : Shared definitions for the register-file port arbiter:
//               op-type encodings, FSM state encoding and the data/address
//               widths of the 32x32 register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_port_arbiter_pkg;

  // Widths follow the project-wide register file definitions.
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

  // Per-client op type as carried on the WR inputs.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Command-issue FSM.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rf_rr_pick2.sv
// ============================================================================
// Module      : rf_rr_pick2
// Description : Combinational 2-way picker. A lone eligible client wins; on a
//               tie the client that did not win last time is chosen.
//               With RF_ARB_FIXED_PRIORITY_EN defined, client 0 always wins a
//               tie and the pointer is ignored.
// Ports       : eligible [1:0] - per-client eligibility
//               ptr            - index of the last granted client
//               winner   [1:0] - one-hot winner (0 when nobody is eligible)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_rr_pick2
  import rf_port_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] winner
);

`ifdef RF_ARB_FIXED_PRIORITY_EN
  // Pointer has no influence in fixed-priority builds.
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

  always_comb begin
    winner = 2'b00;
    case (eligible)
      2'b01: winner = 2'b01;
      2'b10: winner = 2'b10;
      2'b11: begin
`ifdef RF_ARB_FIXED_PRIORITY_EN
        winner = 2'b01;
`else
        // Last winner was client 1 -> client 0 now, and vice versa.
        winner = ptr ? 2'b01 : 2'b10;
`endif
      end
      default: winner = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rf_port_arbiter.sv
// ============================================================================
// Module      : rf_port_arbiter
// Description : Shares the single command port of the 32x32 register file
//               between two clients. One command (read of two addresses, or
//               write of one address) is granted per cycle, round-robin.
//               RF command outputs come straight from registers; read data
//               returns one cycle after the grant with a one-hot RVALID.
//               Optional macro RF_ARB_FIXED_PRIORITY_EN: client 0 wins ties.
// Ports       : CLK, RST (async, active low)
//               REQ[1:0], WR[1:0]            - per-client request / op type
//               ADDR_A0/1, ADDR_B0/1, WDATA0/1 - per-client command fields
//               GNT[1:0], RVALID[1:0]        - one-hot grant / read valid
//               RDATA1, RDATA2               - read data (qualified by RVALID)
//               RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W,
//               RF_DATA_W                    - register file command
//               RF_DATA_R1, RF_DATA_R2       - register file read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic [1:0]            WR,
  input  logic [ADDR_WIDTH-1:0] ADDR_A0,
  input  logic [ADDR_WIDTH-1:0] ADDR_A1,
  input  logic [ADDR_WIDTH-1:0] ADDR_B0,
  input  logic [ADDR_WIDTH-1:0] ADDR_B1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic [1:0]            GNT,
  output logic [1:0]            RVALID,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [DATA_WIDTH-1:0] RDATA2,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  arb_state_t            state_q, state_d;
  logic                  issue;
  logic [1:0]            eligible;
  logic [1:0]            winner;
  logic                  win_idx;
  logic                  ptr_q;

  logic [1:0]            gnt_q;
  logic                  rd_q, wr_q;
  logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r2_q, addr_w_q;
  logic [DATA_WIDTH-1:0] data_w_q;

  // Read-return tracker: set the cycle after a read issue, overlapping
  // whatever is issued next.
  logic                  resp_q;
  logic                  resp_client_q;

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr_a, sel_addr_b;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A client being acknowledged this cycle still has its REQ up; masking
  // with the current grant keeps it from being granted twice.
  assign eligible = REQ & ~gnt_q;

  rf_rr_pick2 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (winner)
  );

  assign win_idx    = winner[1];
  assign sel_wr     = WR[win_idx];
  assign sel_addr_a = win_idx ? ADDR_A1 : ADDR_A0;
  assign sel_addr_b = win_idx ? ADDR_B1 : ADDR_B0;
  assign sel_wdata  = win_idx ? WDATA1  : WDATA0;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        if (|eligible) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b1;
      gnt_q         <= 2'b00;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_r1_q     <= '0;
      addr_r2_q     <= '0;
      addr_w_q      <= '0;
      data_w_q      <= '0;
      resp_q        <= 1'b0;
      resp_client_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_q        <= rd_q;
      resp_client_q <= gnt_q[1];
      if (issue) begin
        gnt_q <= winner;
        ptr_q <= win_idx;
        rd_q  <= (sel_wr == OP_READ);
        wr_q  <= (sel_wr == OP_WRITE);
        if (sel_wr == OP_WRITE) begin
          addr_w_q <= sel_addr_a;
          data_w_q <= sel_wdata;
        end else begin
          addr_r1_q <= sel_addr_a;
          addr_r2_q <= sel_addr_b;
        end
      end else begin
        // Address/data registers deliberately hold their last values.
        gnt_q <= 2'b00;
        rd_q  <= 1'b0;
        wr_q  <= 1'b0;
      end
    end
  end

  assign GNT        = gnt_q;
  assign RF_READ    = rd_q;
  assign RF_WRITE   = wr_q;
  assign RF_ADDR_R1 = addr_r1_q;
  assign RF_ADDR_R2 = addr_r2_q;
  assign RF_ADDR_W  = addr_w_q;
  assign RF_DATA_W  = data_w_q;

  assign RVALID = resp_q ? (resp_client_q ? 2'b10 : 2'b01) : 2'b00;
  // Register file data passes straight through, forced to zero when no read
  // is returning so the outputs are quiet in reset and between reads.
  assign RDATA1 = resp_q ? RF_DATA_R1 : '0;
  assign RDATA2 = resp_q ? RF_DATA_R2 : '0;

endmodule

`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
// ============================================================================
// Module      : tb_rf_port_arbiter
// Description : Self-checking bench for rf_port_arbiter with a behavioural
//               32x32 register file attached. Cycle table of directed
//               vectors plus hand-written reset / single-client sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rf_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  REQ = 2'b00;
  logic [1:0]  WR  = 2'b00;
  logic [4:0]  ADDR_A0 = '0, ADDR_A1 = '0, ADDR_B0 = '0, ADDR_B1 = '0;
  logic [31:0] WDATA0 = '0, WDATA1 = '0;
  logic [1:0]  GNT, RVALID;
  logic [31:0] RDATA1, RDATA2;
  logic        RF_READ, RF_WRITE;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [31:0] RF_DATA_W;
  logic [31:0] RF_DATA_R1, RF_DATA_R2;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rf_port_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .WR         (WR),
    .ADDR_A0    (ADDR_A0),
    .ADDR_A1    (ADDR_A1),
    .ADDR_B0    (ADDR_B0),
    .ADDR_B1    (ADDR_B1),
    .WDATA0     (WDATA0),
    .WDATA1     (WDATA1),
    .GNT        (GNT),
    .RVALID     (RVALID),
    .RDATA1     (RDATA1),
    .RDATA2     (RDATA2),
    .RF_READ    (RF_READ),
    .RF_WRITE   (RF_WRITE),
    .RF_ADDR_R1 (RF_ADDR_R1),
    .RF_ADDR_R2 (RF_ADDR_R2),
    .RF_ADDR_W  (RF_ADDR_W),
    .RF_DATA_W  (RF_DATA_W),
    .RF_DATA_R1 (RF_DATA_R1),
    .RF_DATA_R2 (RF_DATA_R2)
  );

  // Behavioural register file: captures reads and writes on the clock edge.
  logic [31:0] mem [0:31];
  logic        clear_mem = 1'b1;
  always @(posedge CLK) begin
    if (clear_mem) begin
      for (int k = 0; k < 32; k++) mem[k] <= '0;
      RF_DATA_R1 <= '0;
      RF_DATA_R2 <= '0;
    end else begin
      if (RF_WRITE) mem[RF_ADDR_W] <= RF_DATA_W;
      if (RF_READ) begin
        RF_DATA_R1 <= mem[RF_ADDR_R1];
        RF_DATA_R2 <= mem[RF_ADDR_R2];
      end
    end
  end

  typedef struct {
    logic [1:0]  req, wr;
    logic [4:0]  a0, b0, a1, b1;
    logic [31:0] d0, d1;
    logic [1:0]  gnt;
    logic        rd, wrt;
    logic [4:0]  aw;
    logic [31:0] dw;
    logic [4:0]  r1, r2;
    logic [1:0]  rv;
    logic [31:0] q1, q2;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] DB = 32'hDEADBEEF;

  task automatic add(input logic [31:0] req, wr, a0, b0, d0, a1, b1, d1,
                     input logic [31:0] gnt, rd, wrt, aw, dw, r1, r2, rv, q1, q2);
    vec_t v;
    v.req = req[1:0]; v.wr = wr[1:0];
    v.a0 = a0[4:0]; v.b0 = b0[4:0]; v.d0 = d0;
    v.a1 = a1[4:0]; v.b1 = b1[4:0]; v.d1 = d1;
    v.gnt = gnt[1:0]; v.rd = rd[0]; v.wrt = wrt[0];
    v.aw = aw[4:0]; v.dw = dw; v.r1 = r1[4:0]; v.r2 = r2[4:0];
    v.rv = rv[1:0]; v.q1 = q1; v.q2 = q2;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " GNT"},        {30'b0, GNT},    {30'b0, v.gnt});
    chk({tag, " RF_READ"},    {31'b0, RF_READ},  {31'b0, v.rd});
    chk({tag, " RF_WRITE"},   {31'b0, RF_WRITE}, {31'b0, v.wrt});
    chk({tag, " RF_ADDR_W"},  {27'b0, RF_ADDR_W},  {27'b0, v.aw});
    chk({tag, " RF_DATA_W"},  RF_DATA_W, v.dw);
    chk({tag, " RF_ADDR_R1"}, {27'b0, RF_ADDR_R1}, {27'b0, v.r1});
    chk({tag, " RF_ADDR_R2"}, {27'b0, RF_ADDR_R2}, {27'b0, v.r2});
    chk({tag, " RVALID"},     {30'b0, RVALID}, {30'b0, v.rv});
    chk({tag, " RDATA1"},     RDATA1, v.q1);
    chk({tag, " RDATA2"},     RDATA2, v.q2);
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z.req = '0; z.wr = '0; z.a0 = '0; z.b0 = '0; z.a1 = '0; z.b1 = '0;
    z.d0 = '0; z.d1 = '0; z.gnt = '0; z.rd = 1'b0; z.wrt = 1'b0;
    z.aw = '0; z.dw = '0; z.r1 = '0; z.r2 = '0; z.rv = '0; z.q1 = '0; z.q2 = '0;
    check_vec(tag, z);
  endtask

  task automatic drive(input vec_t v);
    REQ = v.req; WR = v.wr;
    ADDR_A0 = v.a0; ADDR_B0 = v.b0; WDATA0 = v.d0;
    ADDR_A1 = v.a1; ADDR_B1 = v.b1; WDATA1 = v.d1;
  endtask

  // Read and write must never be issued together.
  always @(negedge CLK) begin
    if (RST) chk("rd_wr_exclusive", {31'b0, RF_READ & RF_WRITE}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ------------------------------------------------------------------
    // Vector table: inputs driven before an edge, outputs expected after.
    //   req  wr   a0 b0 d0    a1 b1 d1     gnt rd wr aw dw    r1 r2 rv  q1   q2
    // ------------------------------------------------------------------
    // Both clients write continuously: strict alternation, client 0 first.
    add(2'b11, 2'b11, 1, 0, 'h11, 8, 0, 'h22,  2'b01, 0, 1, 1, 'h11, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 1, 0, 'h11, 8, 0, 'h22,  2'b10, 0, 1, 8, 'h22, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 2, 0, 'h11, 8, 0, 'h22,  2'b01, 0, 1, 2, 'h11, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 2, 0, 'h11, 9, 0, 'h22,  2'b10, 0, 1, 9, 'h22, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 3, 0, 'h11, 9, 0, 'h22,  2'b01, 0, 1, 3, 'h11, 0, 0, 0, 0, 0);
    add(2'b11, 2'b11, 3, 0, 'h11, 10, 0, 'h22, 2'b10, 0, 1, 10, 'h22, 0, 0, 0, 0, 0);
    add(2'b10, 2'b11, 3, 0, 'h11, 10, 0, 'h22, 2'b00, 0, 0, 10, 'h22, 0, 0, 0, 0, 0);
    // Client 0 writes DEADBEEF to r5; client 1 reads r5 the very next cycle,
    // then client 0 reads r5 back.
    add(2'b01, 2'b01, 5, 0, DB, 0, 0, 0,       2'b01, 0, 1, 5, DB, 0, 0, 0, 0, 0);
    add(2'b11, 2'b01, 5, 0, DB, 5, 5, 0,       2'b10, 1, 0, 5, DB, 5, 5, 0, 0, 0);
    add(2'b11, 2'b00, 5, 5, 0, 5, 5, 0,        2'b01, 1, 0, 5, DB, 5, 5, 2'b10, DB, DB);
    add(2'b01, 2'b00, 5, 5, 0, 5, 5, 0,        2'b00, 0, 0, 5, DB, 5, 5, 2'b01, DB, DB);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 5, 5, 0, 0, 0);
    // Readback of the alternating writes.
    add(2'b01, 2'b00, 1, 2, 0, 0, 0, 0,        2'b01, 1, 0, 5, DB, 1, 2, 0, 0, 0);
    add(2'b11, 2'b00, 1, 2, 0, 8, 10, 0,       2'b10, 1, 0, 5, DB, 8, 10, 2'b01, 'h11, 'h11);
    add(2'b11, 2'b00, 3, 9, 0, 8, 10, 0,       2'b01, 1, 0, 5, DB, 3, 9, 2'b10, 'h22, 'h22);
    add(2'b01, 2'b00, 3, 9, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 3, 9, 2'b01, 'h11, 'h22);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 3, 9, 0, 0, 0);
    // Tie after idle with client 0 as last winner.
`ifdef RF_ARB_FIXED_PRIORITY_EN
    add(2'b11, 2'b00, 4, 5, 0, 1, 8, 0,        2'b01, 1, 0, 5, DB, 4, 5, 0, 0, 0);
    add(2'b11, 2'b00, 4, 5, 0, 1, 8, 0,        2'b10, 1, 0, 5, DB, 1, 8, 2'b01, 0, DB);
    add(2'b10, 2'b00, 4, 5, 0, 1, 8, 0,        2'b00, 0, 0, 5, DB, 1, 8, 2'b10, 'h11, 'h22);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 1, 8, 0, 0, 0);
`else
    add(2'b11, 2'b00, 4, 5, 0, 1, 8, 0,        2'b10, 1, 0, 5, DB, 1, 8, 0, 0, 0);
    add(2'b11, 2'b00, 4, 5, 0, 1, 8, 0,        2'b01, 1, 0, 5, DB, 4, 5, 2'b10, 'h11, 'h22);
    add(2'b01, 2'b00, 4, 5, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 4, 5, 2'b01, 0, DB);
    add(2'b00, 2'b00, 0, 0, 0, 0, 0, 0,        2'b00, 0, 0, 5, DB, 4, 5, 0, 0, 0);
`endif

    // ------------------------------------------------------------------
    // Reset: both clients requesting, nothing may come out.
    // ------------------------------------------------------------------
    REQ = 2'b11;
    WR  = 2'b11;
    #8;
    check_zero("reset");
    clear_mem = 1'b0;
    REQ = 2'b00;
    #4 RST = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i]);
      @(posedge CLK);
      #1;
      check_vec($sformatf("v%0d", i), tbl[i]);
    end

    // ------------------------------------------------------------------
    // Client 1 alone, three writes: grant every other cycle.
    // ------------------------------------------------------------------
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      REQ = 2'b10; WR = 2'b10;
      ADDR_A1 = 5'(20 + i / 2);
      WDATA1  = 32'h100 + 32'(i / 2);
      @(posedge CLK);
      #1;
      chk($sformatf("solo%0d GNT", i), {30'b0, GNT}, (i % 2 == 0) ? 32'd2 : 32'd0);
      chk($sformatf("solo%0d RF_WRITE", i), {31'b0, RF_WRITE}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("solo%0d RF_READ", i), {31'b0, RF_READ}, 32'd0);
      chk($sformatf("solo%0d RF_ADDR_W", i), {27'b0, RF_ADDR_W}, 32'(20 + i / 2));
    end
    @(negedge CLK);
    REQ = 2'b00;

    // ------------------------------------------------------------------
    // Reset asserted during a read issue cycle.
    // ------------------------------------------------------------------
    @(negedge CLK);
    REQ = 2'b01; WR = 2'b00; ADDR_A0 = 5'd20; ADDR_B0 = 5'd21;
    @(posedge CLK);
    #1;
    chk("rdissue GNT", {30'b0, GNT}, 32'd1);
    chk("rdissue RF_READ", {31'b0, RF_READ}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge CLK);
    REQ = 2'b00;
    @(posedge CLK);
    #1;
    check_zero("reset_held");
    #2 RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post_reset%0d RVALID", i), {30'b0, RVALID}, 32'd0);
      chk($sformatf("post_reset%0d GNT", i), {30'b0, GNT}, 32'd0);
    end
    // Pointer was reset, so client 0 takes the first tie again.
    @(negedge CLK);
    REQ = 2'b11; WR = 2'b11; ADDR_A0 = 5'd7; ADDR_A1 = 5'd7;
    @(posedge CLK);
    #1;
    chk("post_reset tie GNT", {30'b0, GNT}, 32'd1);
    @(negedge CLK);
    REQ = 2'b00;
    @(posedge CLK);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
